// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: 16-bit stereo I2S transmitter with a one-sample holding register.
// Every output is generated on the clk_sys domain. The bit clock is div_cnt-derived:
// BCK toggles every CLK_DIV clk_sys cycles. Data changes on BCK falling edges,
// and is delayed by one bit relative to LRCK as in standard I2S.
// Optional build macro: I2S_UNDERRUN_MUTE_EN. When it is defined, a starved frame plays
// silence. Otherwise the last good frame is repeated.
module i2s_audio_tx #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        I2S_BCK,
  output logic        I2S_LRCK,
  output logic        I2S_DATA,
  output logic        underrun
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [4:0]  bit_cnt_next;
  logic [31:0] shift_reg;
  logic [31:0] hold_data;
  logic [31:0] underrun_frame;
  logic        hold_full;
  logic        div_wrap;
  logic        fall_edge;
  logic        frame_load;
  logic        transfer;

  assign div_wrap     = (div_cnt == DIV_LAST);
  assign fall_edge    = div_wrap & I2S_BCK;
  assign bit_cnt_next = bit_cnt + 5'd1;
  assign frame_load   = fall_edge & (bit_cnt_next == 5'd0);
  assign sample_ready = ~hold_full;
  assign transfer     = sample_valid & ~hold_full;

  // Half-period divider: wrap at CLK_DIV-1 and toggle the bit clock.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt <= 8'd0;
      I2S_BCK <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= 8'd0;
      I2S_BCK <= ~I2S_BCK;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Slot counter advances on each BCK falling edge; word select follows its MSB.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt  <= 5'd31;
      I2S_LRCK <= 1'b1;
    end else if (fall_edge) begin
      bit_cnt  <= bit_cnt_next;
      I2S_LRCK <= bit_cnt_next[4];
    end
  end

  // Serialiser: the MSB leaves on every falling edge, so the old frame's LSB goes out during the load slot.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      shift_reg <= 32'h0;
      I2S_DATA  <= 1'b0;
    end else if (fall_edge) begin
      I2S_DATA <= shift_reg[31];
      if (frame_load) begin
        shift_reg <= hold_full ? hold_data : underrun_frame;
      end else begin
        shift_reg <= {shift_reg[30:0], 1'b0};
      end
    end
  end

  // Holding register: a frame load empties it first, so a load never coincides with a capture while full.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= 32'h0;
    end else begin
      if (transfer) begin
        hold_data <= {left_in, right_in};
      end
      if (frame_load && hold_full) begin
        hold_full <= 1'b0;
      end else if (transfer) begin
        hold_full <= 1'b1;
      end
    end
  end

  // One-cycle pulse when a frame starts without a fresh sample waiting.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      underrun <= 1'b0;
    end else begin
      underrun <= frame_load & ~hold_full;
    end
  end

`ifdef I2S_UNDERRUN_MUTE_EN
  assign underrun_frame = 32'h0;
`else
  logic [31:0] last_frame;

  // Remember the last frame actually taken from the holding register for replay on starvation.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_frame <= 32'h0;
    end else if (frame_load && hold_full) begin
      last_frame <= hold_data;
    end
  end

  assign underrun_frame = last_frame;
`endif

endmodule
